// File: rtl/gd_update_seq.sv
// -----------------------------------------------------------------------------
// gd_update_seq
// Sequencer for one gradient-descent update pass over N_PARAMS Q24.8
// parameters. For each index it reads theta/delta from the parameter store,
// drives the shared fixed-point add/sub unit, saturates on overflow, and
// writes the result back. Each element takes four cycles: READ, WAIT, EXEC
// and WRITE.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, mode       run request (IDLE only); 0 = theta+delta, 1 = theta-delta
//   busy, done        run in progress (READ..WRITE); one-cycle end-of-run pulse
//   rd_en, rd_addr    parameter-store read request and index
//   rd_theta/delta    read data, valid the cycle after rd_en
//   au_a/au_b/au_sub_n_add   operands and op select to the add/sub unit
//   au_result/au_overflow    combinational result and overflow from the unit
//   wr_en/wr_addr/wr_data    write-back of the updated parameter
//   sat_cnt           number of saturated writes in the current/last run
// -----------------------------------------------------------------------------
module gd_update_seq #(
    parameter int N_PARAMS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_theta,
    input  logic [31:0]       rd_delta,
    output logic [31:0]       au_a,
    output logic [31:0]       au_b,
    output logic              au_sub_n_add,
    input  logic [31:0]       au_result,
    input  logic              au_overflow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   sat_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EXEC,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PARAMS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              mode_q;
    logic [31:0]       sat_value;

    // On overflow the unit's result sign is the opposite of the true sign, so
    // a negative-looking result means the true value overflowed upwards.
    always_comb begin
        sat_value = au_result;
        if (au_overflow) begin
            sat_value = au_result[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
    end

    // au_a/au_b double as the operand registers: they load at the end of
    // WAIT and hold until the next element's WAIT, so the unit inputs only
    // change on entry to EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            mode_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            au_a         <= '0;
            au_b         <= '0;
            au_sub_n_add <= 1'b0;
            sat_cnt      <= '0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        idx     <= '0;
                        mode_q  <= mode;
                        sat_cnt <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    au_a         <= rd_theta;
                    au_b         <= rd_delta;
                    au_sub_n_add <= mode_q;
                    state        <= EXEC;
                end
                EXEC: begin
                    wr_en   <= 1'b1;
                    wr_addr <= idx;
                    wr_data <= sat_value;
                    if (au_overflow) begin
                        sat_cnt <= sat_cnt + 1'b1;
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gd_update_seq.md
GD_UPDATE_SEQ -- requirements
Module: gd_update_seq

Interface
REQ-001 Parameter: N_PARAMS, default 4, number of Q24.8 parameters updated per run (>=1).
REQ-002 Parameter: ADDR_W, default 2, address width; 2**ADDR_W >= N_PARAMS.
REQ-003 Clocking: one clock, clk; reset is rst, asynchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: start  input  1  run request, sampled only in IDLE.
REQ-007 Port: mode  input  1  0 = theta+delta, 1 = theta-delta; latched when start is accepted.
REQ-008 Port: busy  output  1  high while a run is in progress (READ..WRITE states).
REQ-009 Port: done  output  1  one-cycle pulse at end of run.
REQ-010 Port: rd_en / rd_addr  output  1 / ADDR_W  parameter-store read request and index.
REQ-011 Port: rd_theta / rd_delta  input  32 / 32  signed Q24.8 read data, valid the cycle after rd_en.
REQ-012 Port: au_a / au_b / au_sub_n_add  output  32 / 32 / 1  operands and op select to the shared fixed-point add/sub unit.
REQ-013 Port: au_result / au_overflow  input  32 / 1  combinational result and overflow flag from the add/sub unit.
REQ-014 Port: wr_en / wr_addr / wr_data  output  1 / ADDR_W / 32  write-back of updated parameter.
REQ-015 Port: sat_cnt  output  ADDR_W+1  number of saturated writes in current/last run.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, EXEC, WRITE, DONE; all outputs registered.
REQ-017 IDLE -> READ when start=1; index i cleared to 0, mode latched, sat_cnt cleared to 0 on the same edge.
REQ-018 READ: rd_en=1, rd_addr=i for exactly one cycle; -> WAIT.
REQ-019 WAIT: rd_theta/rd_delta captured into operand registers at end of cycle; -> EXEC.
REQ-020 EXEC: au_a=theta reg, au_b=delta reg, au_sub_n_add=latched mode; au_result/au_overflow sampled at end of cycle; -> WRITE.
REQ-021 Saturation: if au_overflow=1, stored result = 0x7FFFFFFF when au_result[31]=1, else 0x80000000; sat_cnt increments by 1 (wraps, never blocks); if au_overflow=0, stored result = au_result.
REQ-022 WRITE: wr_en=1, wr_addr=i, wr_data=stored result for one cycle; -> DONE if i==N_PARAMS-1, else READ with i+1.
REQ-023 DONE: done=1 for one cycle, busy=0; -> IDLE.
REQ-024 Latency: element i READ in cycle 4i+1 after the start-accept edge, WRITE in cycle 4i+4; done in cycle 4*N_PARAMS+1; throughput 4 cycles/element.
REQ-025 start during busy or DONE SHALL be ignored; mode changes after acceptance SHALL have no effect.
REQ-026 rd_en and wr_en SHALL never be high in the same cycle; wr_en SHALL be high exactly N_PARAMS times per run.
REQ-027 Outside EXEC, au_a/au_b/au_sub_n_add SHALL hold their last values (no toggling required).

Reset
REQ-028 On rst=1 (any state, asynchronously): state=IDLE, i=0, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, au_a=0, au_b=0, au_sub_n_add=0, sat_cnt=0.
REQ-029 Reset mid-run SHALL abort with no further writes; next run starts from index 0 after a new start.

Verification
REQ-030 N=4, mode=1, theta[0]=0x00000500, delta[0]=0x00000100 -> wr_data[0]=0x00000400, sat_cnt=0.
REQ-031 mode=1, theta=0x7FFFFF00, delta=0xFFFFFF00 (unit: result 0x80000000, ovf=1) -> wr_data=0x7FFFFFFF, sat_cnt=1.
REQ-032 mode=0, theta=0x80000000, delta=0xFFFFFF00 (unit: 0x7FFFFF00, ovf=1) -> wr_data=0x80000000, sat_cnt incremented.
REQ-033 N=4, start at edge 0, start re-pulsed in cycles 5 and 17 -> done only in cycle 17, wr_en in cycles 4, 8, 12, 16, no second run.
REQ-034 rst asserted in cycle 6 (mid element 1) -> all outputs at reset values immediately, no wr_en until next accepted start.
REQ-035 Back-to-back runs: start held high through DONE -> second run accepted from IDLE, sat_cnt cleared, addresses restart at 0.
